minus_offset: RTL and testbench

//  Computes sum = K - offset on signed two's-complement data, with K = 2 by default.

---
 rtl/minus_offset_pkg.sv | 15 +
 rtl/sat_clip.sv | 43 ++++
 rtl/minus_offset.sv | 64 ++++++
 tb/tb_minus_offset.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/minus_offset_pkg.sv
// Shared types and constants for the minus_offset datapath stage.
//   DATA_W : default data width of offset/sum
//   SMAX   : largest signed value representable in DATA_W bits
//   SMIN   : smallest signed value representable in DATA_W bits
//   data_t : signed data word of DATA_W bits
package minus_offset_pkg;

   localparam int unsigned DATA_W = 16;

   localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef logic signed [DATA_W-1:0] data_t;

endpackage : minus_offset_pkg

// File: rtl/sat_clip.sv
// Reduces a WIDTH+2 bit signed value to WIDTH bits, clamping or wrapping.
//   value    : WIDTH+2 bit signed input
//   sat_en   : 1 clamps out-of-range values, 0 wraps (keeps low WIDTH bits)
//   result_c : WIDTH bit signed result (combinational)
//   ovf_c    : value lies outside the WIDTH bit signed range (combinational)
module sat_clip #(
   parameter int unsigned WIDTH = 16
) (
   input  logic signed [WIDTH+1:0] value,
   input  logic                    sat_en,
   output logic signed [WIDTH-1:0] result_c,
   output logic                    ovf_c
);

   localparam logic signed [WIDTH-1:0] RMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] RMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0] top_bits;
   logic       in_range;
   logic       too_high;
   logic       too_low;

   // In range exactly when the three top bits are all copies of the sign bit.
   always_comb begin
      top_bits = value[WIDTH+1:WIDTH-1];
      in_range = (top_bits == 3'b000) || (top_bits == 3'b111);
      too_high = !in_range && !value[WIDTH+1];
      too_low  = !in_range &&  value[WIDTH+1];
   end

   always_comb begin
      result_c = value[WIDTH-1:0];
      ovf_c    = !in_range;
      if (sat_en) begin
         if (too_high) begin
            result_c = RMAX;
         end else if (too_low) begin
            result_c = RMIN;
         end
      end
   end

endmodule : sat_clip

// File: rtl/minus_offset.sv
// Registered stage computing sum = K_CONST - offset, saturated or wrapped.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : offset is valid this cycle
//   offset    : signed operand
//   out_valid : sum/ovf updated by the previous edge
//   sum       : K_CONST - offset, clamped (SATURATE=1) or wrapped (SATURATE=0)
//   ovf       : exact difference was outside the WIDTH bit signed range
module minus_offset
   import minus_offset_pkg::*;
#(
   parameter int unsigned WIDTH    = DATA_W,
   parameter int          K_CONST  = 2,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] offset,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] sum,
   output logic                    ovf
);

   localparam int unsigned XW = WIDTH + 2;

   localparam logic signed [XW-1:0] K_EXT = XW'(K_CONST);

   logic signed [XW-1:0]    offset_ext;
   logic signed [XW-1:0]    diff;
   logic signed [WIDTH-1:0] clip_c;
   logic                    clip_ovf_c;

   // Two guard bits make the difference exact for every offset.
   always_comb begin
      offset_ext = {{2{offset[WIDTH-1]}}, offset};
      diff       = K_EXT - offset_ext;
   end

   sat_clip #(
      .WIDTH (WIDTH)
   ) u_sat_clip (
      .value    (diff),
      .sat_en   (SATURATE),
      .result_c (clip_c),
      .ovf_c    (clip_ovf_c)
   );

   // Result registers only load on valid cycles so idle offsets never leak in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum <= clip_c;
            ovf <= clip_ovf_c;
         end
      end
   end

endmodule : minus_offset

// File: tb/tb_minus_offset.sv
module tb_minus_offset;
   import minus_offset_pkg::*;

   typedef struct {
      logic  v;
      data_t sat;
      data_t wrp;
      logic  ovf;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  in_valid = 1'b0;
   data_t offset = '0;
   logic  out_valid, ovf, w_out_valid, w_ovf;
   data_t sum, w_sum;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t sb[$];
   data_t m_sat = '0;
   data_t m_wrp = '0;
   logic  m_ovf = 1'b0;

   always #5 clk = ~clk;

   minus_offset #(.WIDTH(16), .K_CONST(2), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .offset(offset),
      .out_valid(out_valid), .sum(sum), .ovf(ovf)
   );

   minus_offset #(.WIDTH(16), .K_CONST(2), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .offset(offset),
      .out_valid(w_out_valid), .sum(w_sum), .ovf(w_ovf)
   );

   // Reference: exact integer arithmetic, then clamp / wrap; idle cycles hold.
   function automatic exp_t model(input logic v, input data_t off);
      exp_t e;
      int   d;
      d = 2 - int'(off);
      if (v) begin
         m_ovf = (d > 32767) || (d < -32768);
         m_wrp = 16'(d);
         if (d > 32767)       m_sat = 16'sd32767;
         else if (d < -32768) m_sat = -16'sd32768;
         else                 m_sat = 16'(d);
      end
      e.v = v; e.sat = m_sat; e.wrp = m_wrp; e.ovf = m_ovf;
      return e;
   endfunction

   // Drive one cycle from a negedge; outputs settle by the next negedge.
   task automatic drive(input logic v, input data_t off);
      in_valid = v;
      offset   = v ? off : data_t'($urandom);
      sb.push_back(model(v, off));
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || sum !== 16'sd0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_initial: got v=%b sum=%0d ovf=%b, want 0 0 0", out_valid, sum, ovf);
      end
      rst = 1'b0;
      drive(1'b1, 16'sd9);
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || sum !== e.sat || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL reset_pre: got v=%b sum=%0d ovf=%b, want 1 %0d %b", out_valid, sum, ovf, e.sat, e.ovf);
      end
      // In-flight valid, reset asserted mid-cycle before the capturing edge.
      in_valid = 1'b1;
      offset   = 16'sd5;
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || sum !== 16'sd0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got v=%b sum=%0d ovf=%b, want 0 0 0", out_valid, sum, ovf);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || sum !== 16'sd0 || w_sum !== 16'sd0 || w_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got v=%b sum=%0d wsum=%0d, want 0 0 0", out_valid, sum, w_sum);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      m_sat = '0; m_wrp = '0; m_ovf = 1'b0;
      sb.delete();
      drive(1'b0, '0);
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b0 || sum !== e.sat || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL reset_release: got v=%b sum=%0d ovf=%b, want 0 %0d %b", out_valid, sum, ovf, e.sat, e.ovf);
      end
   endtask

   // Table-driven directed values with hand-derived expectations cross-checked.
   task automatic test_directed(input string name, input data_t off,
                                input data_t want_sat, input data_t want_wrp, input logic want_ovf);
      exp_t e;
      drive(1'b1, off);
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || sum !== want_sat || ovf !== want_ovf ||
          w_out_valid !== 1'b1 || w_sum !== want_wrp || w_ovf !== want_ovf ||
          e.sat !== want_sat || e.wrp !== want_wrp) begin
         n_fail++;
         $display("FAIL %s off=%0d: got v=%b sum=%0d ovf=%b wsum=%0d wovf=%b, want 1 %0d %b %0d",
                  name, off, out_valid, sum, ovf, w_sum, w_ovf, want_sat, want_ovf, want_wrp);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      data_t want[3] = '{16'sd1, 16'sd0, -16'sd1};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, data_t'(i + 1));
         e = sb.pop_front();
         n_tests++;
         if (out_valid !== 1'b1 || sum !== want[i] || ovf !== 1'b0 || e.sat !== want[i]) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got v=%b sum=%0d ovf=%b, want 1 %0d 0", i, out_valid, sum, ovf, want[i]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, '0);
         e = sb.pop_front();
         n_tests++;
         if (out_valid !== 1'b0 || sum !== -16'sd1 || ovf !== 1'b0 || w_sum !== -16'sd1) begin
            n_fail++;
            $display("FAIL hold[%0d]: got v=%b sum=%0d wsum=%0d ovf=%b, want 0 -1 -1 0", i, out_valid, sum, w_sum, ovf);
         end
      end
   endtask

   task automatic test_random(input int n);
      exp_t e;
      int   bad = 0;
      for (int i = 0; i < n; i++) begin
         drive(1'($urandom_range(0, 3) != 0), data_t'($urandom));
         e = sb.pop_front();
         n_tests++;
         if (out_valid !== e.v || sum !== e.sat || ovf !== e.ovf ||
             w_out_valid !== e.v || w_sum !== e.wrp || w_ovf !== e.ovf) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL random[%0d]: got v=%b sum=%0d ovf=%b wsum=%0d wovf=%b, want %b %0d %b %0d",
                        i, out_valid, sum, ovf, w_sum, w_ovf, e.v, e.sat, e.ovf, e.wrp);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("basic_pos",  16'sd5,      -16'sd3,     -16'sd3,     1'b0);
      test_directed("basic_neg",  -16'sd5,     16'sd7,      16'sd7,      1'b0);
      test_directed("basic_zero", 16'sd0,      16'sd2,      16'sd2,      1'b0);
      test_directed("max_off",    16'sd32767,  -16'sd32765, -16'sd32765, 1'b0);
      test_directed("min_off",    -16'sd32768, 16'sd32767,  -16'sd32766, 1'b1);
      test_directed("min_off_p1", -16'sd32767, 16'sd32767,  -16'sd32767, 1'b1);
      test_directed("min_off_p2", -16'sd32766, 16'sd32767,  -16'sd32768, 1'b1);
      test_directed("sat_edge",   -16'sd32765, 16'sd32767,  16'sd32767,  1'b0);
      test_back_to_back();
      test_random(10000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_minus_offset
